// File: rtl/skin_pkg.sv
// Shared encodings and defaults for the skin detector: pixel modes, control bit
// positions, statistics counter width and the YCbCr skin thresholds.
package skin_pkg;

    localparam int CNT_W = 21;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam int C_DE = 0;
    localparam int C_HS = 1;
    localparam int C_VS = 2;

    localparam logic [7:0] Y_MIN_DEF  = 8'd40;
    localparam logic [7:0] CB_MIN_DEF = 8'd77;
    localparam logic [7:0] CB_MAX_DEF = 8'd127;
    localparam logic [7:0] CR_MIN_DEF = 8'd133;
    localparam logic [7:0] CR_MAX_DEF = 8'd173;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'd0,
        MODE_MASK      = 2'd1,
        MODE_BINARY    = 2'd2,
        MODE_HIGHLIGHT = 2'd3
    } mode_e;

    typedef enum logic {
        WAIT_VS = 1'b0,
        COUNT   = 1'b1
    } stat_state_e;

endpackage

// File: rtl/maj3_window.sv
// Three-tap horizontal window {prev, cur, next} over the raw skin decision,
// producing the 2-of-3 majority. The window empties across blanking.
module maj3_window (
    input  logic clk,
    input  logic rst,
    input  logic next_raw,
    input  logic next_de,
    output logic maj
);

    logic prev;
    logic cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= 1'b0;
            cur  <= 1'b0;
        end else if (!next_de) begin
            prev <= 1'b0;
            cur  <= 1'b0;
        end else begin
            prev <= cur;
            cur  <= next_raw;
        end
    end

    // next_raw comes straight from stage 1, giving one pixel of look-ahead
    assign maj = (prev & cur) | (prev & next_raw) | (cur & next_raw);

endmodule

// File: rtl/skin_detect.sv
// YCbCr skin classifier with 3-tap majority filtering, a per-pixel output mux
// and a per-frame skin-pixel counter; three-cycle pixel latency.
//
// state   | meaning
// WAIT_VS | after reset, counter held at 0 until the first vsync rise
// COUNT   | counting filtered skin pixels; each vsync rise reports and restarts
module skin_detect
    import skin_pkg::*;
#(
    parameter logic [7:0] Y_MIN  = Y_MIN_DEF,
    parameter logic [7:0] CB_MIN = CB_MIN_DEF,
    parameter logic [7:0] CB_MAX = CB_MAX_DEF,
    parameter logic [7:0] CR_MIN = CR_MIN_DEF,
    parameter logic [7:0] CR_MAX = CR_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_r,
    input  logic [7:0]       in_g,
    input  logic [7:0]       in_b,
    input  logic [2:0]       in_c,
    input  logic [7:0]       in_y,
    input  logic [7:0]       in_cb,
    input  logic [7:0]       in_cr,
    input  logic [1:0]       mode,
    output logic [7:0]       out_r,
    output logic [7:0]       out_g,
    output logic [7:0]       out_b,
    output logic [2:0]       out_c,
    output logic             skin_flag,
    output logic [CNT_W-1:0] frame_skin_count,
    output logic             frame_done
);

    logic       raw_d;
    logic       s1_raw;
    logic [7:0] s1_r, s1_g, s1_b;
    logic [2:0] s1_c;
    logic [7:0] s2_r, s2_g, s2_b;
    logic [2:0] s2_c;
    logic [1:0] s2_mode;
    logic       maj;
    logic       flag;
    logic [7:0] pix_r, pix_g, pix_b;

    assign raw_d = (in_y >= Y_MIN) &&
                   (in_cb >= CB_MIN) && (in_cb <= CB_MAX) &&
                   (in_cr >= CR_MIN) && (in_cr <= CR_MAX) &&
                   in_c[C_DE];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_raw  <= 1'b0;
            s1_r    <= 8'd0;
            s1_g    <= 8'd0;
            s1_b    <= 8'd0;
            s1_c    <= 3'd0;
            s2_r    <= 8'd0;
            s2_g    <= 8'd0;
            s2_b    <= 8'd0;
            s2_c    <= 3'd0;
            s2_mode <= 2'd0;
        end else begin
            s1_raw  <= raw_d;
            s1_r    <= in_r;
            s1_g    <= in_g;
            s1_b    <= in_b;
            s1_c    <= in_c;
            s2_r    <= s1_r;
            s2_g    <= s1_g;
            s2_b    <= s1_b;
            s2_c    <= s1_c;
            s2_mode <= mode;
        end
    end

    maj3_window u_window (
        .clk      (clk),
        .rst      (rst),
        .next_raw (s1_raw),
        .next_de  (s1_c[C_DE]),
        .maj      (maj)
    );

    assign flag = maj & s2_c[C_DE];

    always_comb begin
        pix_r = s2_r;
        pix_g = s2_g;
        pix_b = s2_b;
        case (mode_e'(s2_mode))
            MODE_PASS: ;
            MODE_MASK: begin
                if (!flag) begin
                    pix_r = 8'd0;
                    pix_g = 8'd0;
                    pix_b = 8'd0;
                end
            end
            MODE_BINARY: begin
                pix_r = flag ? 8'hFF : 8'd0;
                pix_g = flag ? 8'hFF : 8'd0;
                pix_b = flag ? 8'hFF : 8'd0;
            end
            MODE_HIGHLIGHT: begin
                if (flag) pix_r = 8'hFF;
            end
            default: ;
        endcase
        // blanking is always black, whatever the mode
        if (!s2_c[C_DE]) begin
            pix_r = 8'd0;
            pix_g = 8'd0;
            pix_b = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r     <= 8'd0;
            out_g     <= 8'd0;
            out_b     <= 8'd0;
            out_c     <= 3'd0;
            skin_flag <= 1'b0;
        end else begin
            out_r     <= pix_r;
            out_g     <= pix_g;
            out_b     <= pix_b;
            out_c     <= s2_c;
            skin_flag <= flag;
        end
    end

    stat_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] fsc_d;
    logic             done_d;
    logic             vs_prev;
    logic             vs_rise;
    logic             count_inc;

    assign vs_rise   = out_c[C_VS] & ~vs_prev;
    assign count_inc = out_c[C_DE] & skin_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= WAIT_VS;
            count_q          <= '0;
            frame_skin_count <= '0;
            frame_done       <= 1'b0;
            vs_prev          <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            frame_skin_count <= fsc_d;
            frame_done       <= done_d;
            vs_prev          <= out_c[C_VS];
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        fsc_d   = frame_skin_count;
        done_d  = 1'b0;
        case (state_q)
            WAIT_VS: begin
                count_d = '0;
                if (vs_rise) state_d = COUNT;
            end
            COUNT: begin
                if (vs_rise) begin
                    fsc_d   = count_q;
                    done_d  = 1'b1;
                    // a skin pixel on the vsync edge belongs to the new frame
                    count_d = count_inc ? CNT_W'(1) : '0;
                end else if (count_inc && (count_q != CNT_MAX)) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

endmodule

// File: tb/tb_skin_detect.sv
// Directed bench for skin_detect: a reference model queues the expected output
// of every driven pixel and each cycle's DUT output is checked against it.
module tb_skin_detect;
    import skin_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_r, in_g, in_b, in_y, in_cb, in_cr;
    logic [2:0]  in_c;
    logic [1:0]  mode;
    logic [7:0]  out_r, out_g, out_b;
    logic [2:0]  out_c;
    logic        skin_flag;
    logic [20:0] frame_skin_count;
    logic        frame_done;

    always #5 clk = ~clk;

    skin_detect dut (
        .clk              (clk),
        .rst              (rst),
        .in_r             (in_r),
        .in_g             (in_g),
        .in_b             (in_b),
        .in_c             (in_c),
        .in_y             (in_y),
        .in_cb            (in_cb),
        .in_cr            (in_cr),
        .mode             (mode),
        .out_r            (out_r),
        .out_g            (out_g),
        .out_b            (out_b),
        .out_c            (out_c),
        .skin_flag        (skin_flag),
        .frame_skin_count (frame_skin_count),
        .frame_done       (frame_done)
    );

    typedef struct {
        logic [7:0] r, g, b;
        logic [2:0] c;
        logic       flag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          done_seen = 0;
    logic [1:0]  tb_mode = 2'd0;

    logic        h1_raw, h2_raw;
    logic [7:0]  h1_r, h1_g, h1_b;
    logic [2:0]  h1_c;

    logic        m_counting, m_done, m_vs_prev;
    logic [20:0] m_cnt, m_fsc;

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic model_raw(input logic [7:0] y, cb, cr, input logic de);
        return de && (y >= 8'd40) && (cb >= 8'd77) && (cb <= 8'd127) &&
               (cr >= 8'd133) && (cr <= 8'd173);
    endfunction

    task automatic model_reset();
        exp_t z;
        z.r = 0; z.g = 0; z.b = 0; z.c = 0; z.flag = 0;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
        h1_raw = 0; h2_raw = 0; h1_r = 0; h1_g = 0; h1_b = 0; h1_c = 0;
        m_counting = 0; m_done = 0; m_vs_prev = 0; m_cnt = 0; m_fsc = 0;
    endtask

    task automatic step(input logic [7:0] r, g, b, y, cb, cr, input logic [2:0] c);
        exp_t e, n;
        logic raw, f, vs_rise, inc;
        int   votes;
        @(negedge clk);
        e = exp_q.pop_front();
        chk("out_r", 21'(out_r), 21'(e.r));
        chk("out_g", 21'(out_g), 21'(e.g));
        chk("out_b", 21'(out_b), 21'(e.b));
        chk("out_c", 21'(out_c), 21'(e.c));
        chk("skin_flag", 21'(skin_flag), 21'(e.flag));
        chk("frame_done", 21'(frame_done), 21'(m_done));
        chk("frame_skin_count", frame_skin_count, m_fsc);
        if (frame_done === 1'b1) done_seen++;
        vs_rise = e.c[2] && !m_vs_prev;
        inc     = e.c[0] && e.flag;
        m_done  = 0;
        if (!m_counting) begin
            m_cnt = 0;
            if (vs_rise) m_counting = 1;
        end else if (vs_rise) begin
            m_fsc  = m_cnt;
            m_done = 1;
            m_cnt  = inc ? 21'd1 : 21'd0;
        end else if (inc && m_cnt != 21'h1FFFFF) begin
            m_cnt = m_cnt + 21'd1;
        end
        m_vs_prev = e.c[2];
        in_r = r; in_g = g; in_b = b; in_y = y; in_cb = cb; in_cr = cr; in_c = c;
        mode = tb_mode;
        raw   = model_raw(y, cb, cr, c[0]);
        votes = int'(h2_raw) + int'(h1_raw) + int'(raw);
        f     = h1_c[0] && (votes >= 2);
        n.c = h1_c; n.flag = f;
        n.r = h1_r; n.g = h1_g; n.b = h1_b;
        case (tb_mode)
            2'd1: if (!f) begin n.r = 0; n.g = 0; n.b = 0; end
            2'd2: begin n.r = f ? 8'hFF : 8'h00; n.g = n.r; n.b = n.r; end
            2'd3: if (f) n.r = 8'hFF;
            default: ;
        endcase
        if (!h1_c[0]) begin n.r = 0; n.g = 0; n.b = 0; end
        exp_q.push_back(n);
        h2_raw = h1_raw; h1_raw = raw;
        h1_r = r; h1_g = g; h1_b = b; h1_c = c;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic skin(input int k, input logic [2:0] c);
        for (int i = 0; i < k; i++)
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'd100, 8'd100, 8'd150, c);
    endtask

    task automatic vsync();
        step(0, 0, 0, 0, 0, 0, 3'b100);
        step(0, 0, 0, 0, 0, 0, 3'b100);
        idle(6);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rgb"}, 21'({out_r, out_g, out_b} != 24'd0), 21'd0);
        chk({tag, "_c"}, 21'(out_c), 21'd0);
        chk({tag, "_flag"}, 21'(skin_flag), 21'd0);
        chk({tag, "_done"}, 21'(frame_done), 21'd0);
        chk({tag, "_fsc"}, frame_skin_count, 21'd0);
    endtask

    task automatic boundary(input logic [7:0] y, cb, cr);
        skin(1, 3'b001);
        step(8'h11, 8'h22, 8'h33, y, cb, cr, 3'b001);
        step(8'h44, 8'h55, 8'h66, 8'd10, 8'd10, 8'd10, 3'b001);
        idle(2);
    endtask

    initial begin
        logic [7:0] y, cb, cr;
        in_r = 0; in_g = 0; in_b = 0; in_y = 0; in_cb = 0; in_cr = 0;
        in_c = 0; mode = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        @(posedge clk); #2 rst = 1'b1;

        // run of five skin pixels in binary mode
        tb_mode = 2'd2;
        idle(3);
        skin(5, 3'b001);
        idle(4);

        // isolated skin pixel is rejected in mask mode
        tb_mode = 2'd1;
        step(8'h80, 8'h80, 8'h80, 8'd10, 8'd10, 8'd10, 3'b001);
        skin(1, 3'b001);
        step(8'h80, 8'h80, 8'h80, 8'd10, 8'd10, 8'd10, 3'b001);
        idle(4);

        // threshold edges, each tested pixel seen through majority with one skin neighbour
        tb_mode = 2'd2;
        boundary(8'd100, 8'd77, 8'd150);
        boundary(8'd100, 8'd127, 8'd150);
        boundary(8'd100, 8'd100, 8'd133);
        boundary(8'd100, 8'd100, 8'd173);
        boundary(8'd100, 8'd76, 8'd150);
        boundary(8'd100, 8'd128, 8'd150);
        boundary(8'd100, 8'd100, 8'd132);
        boundary(8'd100, 8'd100, 8'd174);
        boundary(8'd39, 8'd100, 8'd150);
        boundary(8'd40, 8'd100, 8'd150);

        // mixed traffic with mode switching mid-line
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 30; i++) begin
                if (i == 15) tb_mode = 2'(m);
                if (i == 0) tb_mode = 2'(3 - m);
                y  = ($urandom_range(0, 9) < 7) ? 8'd100 : 8'd20;
                cb = ($urandom_range(0, 9) < 8) ? 8'd90 : 8'd140;
                cr = ($urandom_range(0, 9) < 8) ? 8'd160 : 8'd120;
                step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), y, cb, cr,
                     {1'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0)});
            end
        end
        idle(4);

        // frame statistics: first vsync only arms, second reports 1000
        rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        done_seen = 0;
        vsync();
        chk("first_vsync_no_pulse", 21'(done_seen), 21'd0);
        for (int l = 0; l < 10; l++) begin
            skin(100, 3'b001);
            step(0, 0, 0, 0, 0, 0, 3'b010);
            step(0, 0, 0, 0, 0, 0, 3'b010);
        end
        vsync();
        chk("frame_done_pulses", 21'(done_seen), 21'd1);
        chk("frame_count_1000", frame_skin_count, 21'd1000);

        // skin pixel on the vsync edge opens the next frame
        skin(10, 3'b001);
        idle(3);
        skin(1, 3'b101);
        skin(3, 3'b001);
        idle(3);
        chk("edge_pixel_excluded", frame_skin_count, 21'd10);
        vsync();
        chk("edge_pixel_counted", frame_skin_count, 21'd4);
        chk("edge_frame_pulses", 21'(done_seen), 21'd3);

        // saturation
        force dut.count_q = 21'h1FFFF8;
        @(posedge clk);
        #1 release dut.count_q;
        m_cnt = 21'h1FFFF8;
        skin(10, 3'b001);
        idle(3);
        vsync();
        chk("saturated_count", frame_skin_count, 21'h1FFFFF);

        // asynchronous reset mid-frame, partial frame never reported
        skin(6, 3'b001);
        @(posedge clk);
        #2 rst = 1'b0;
        in_r = 0; in_g = 0; in_b = 0; in_y = 0; in_cb = 0; in_cr = 0; in_c = 0;
        #1 chk_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        done_seen = 0;
        skin(8, 3'b001);
        idle(3);
        vsync();
        chk("no_pulse_after_reset", 21'(done_seen), 21'd0);
        chk("count_after_reset", frame_skin_count, 21'd0);
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
